stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer: walks a chain of NUM_STAGES compute stages in order, one at
// a time, for a latched number of passes, with a per-stage watchdog.
//
// Optional feature macro: STAGE_SKIP_EN. When defined, a skip_mask input is
// added; it is latched at start and masked stages are never enabled.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-low reset
//   start          run request, accepted in IDLE only
//   abort          return to IDLE from any state, no done pulse
//   iter_count     passes per run (0 treated as 1), latched at start
//   timeout_limit  max cycles per stage (0 = watchdog off), latched at start
//   stage_done     per-stage completion flags (only the active one is used)
//   skip_mask      (STAGE_SKIP_EN only) stages to bypass, latched at start
//   stage_en       one-hot (or zero) stage enable
//   stage_rst      per-stage reset, high for every stage not enabled
//   busy           high while running
//   done           one-cycle completion pulse
//   error          sticky watchdog failure flag
//   err_stage      index of the stage that timed out
//   cur_stage      index of the active stage, 0 when not running
//   iter_remaining passes left including the current one
module stage_sequencer #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned TIMEOUT_W  = 16,
  parameter int unsigned ITER_W     = 8,
  localparam int unsigned SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ITER_W-1:0]     iter_count,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  input  logic [NUM_STAGES-1:0] stage_done,
`ifdef STAGE_SKIP_EN
  input  logic [NUM_STAGES-1:0] skip_mask,
`endif
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [SW-1:0]         err_stage,
  output logic [SW-1:0]         cur_stage,
  output logic [ITER_W-1:0]     iter_remaining
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         cur_stage_q, cur_stage_d;
  logic [TIMEOUT_W-1:0]  timer_q, timer_d;
  logic [TIMEOUT_W-1:0]  limit_q, limit_d;
  logic [ITER_W-1:0]     iter_rem_q, iter_rem_d;
  logic                  error_q, error_d;
  logic [SW-1:0]         err_stage_q, err_stage_d;
  logic [NUM_STAGES-1:0] stage_en_q, stage_en_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Mask used to pick the first stage at start, and the latched mask used while running
  logic [NUM_STAGES-1:0] start_mask;
  logic [NUM_STAGES-1:0] skip_act;

  // {found, index} of the first unmasked stage at or after a position
  logic [SW:0] nxt_start;
  logic [SW:0] nxt_fwd;
  logic [SW:0] nxt_wrap;
  logic        cur_hit;
  logic        wd_fire;

`ifdef STAGE_SKIP_EN
  logic [NUM_STAGES-1:0] skip_q, skip_d;

  assign start_mask = skip_mask;
  assign skip_act   = skip_q;
`else
  assign start_mask = '0;
  assign skip_act   = '0;
`endif

  // Lowest-index stage >= from whose mask bit is clear
  function automatic logic [SW:0] find_free(input logic [NUM_STAGES-1:0] mask,
                                            input int unsigned from);
    logic          found;
    logic [SW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (!found && (i >= from) && !mask[i]) begin
        found = 1'b1;
        idx   = SW'(i);
      end
    end
    return {found, idx};
  endfunction

  assign nxt_start = find_free(start_mask, 32'd0);
  assign nxt_fwd   = find_free(skip_act, 32'(cur_stage_q) + 32'd1);
  assign nxt_wrap  = find_free(skip_act, 32'd0);
  assign cur_hit   = stage_done[cur_stage_q];
  assign wd_fire   = (limit_q != '0) && (timer_q == limit_q);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cur_stage_q <= '0;
      timer_q     <= '0;
      limit_q     <= '0;
      iter_rem_q  <= '0;
      error_q     <= 1'b0;
      err_stage_q <= '0;
      stage_en_q  <= '0;
      stage_rst_q <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef STAGE_SKIP_EN
      skip_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_stage_q <= cur_stage_d;
      timer_q     <= timer_d;
      limit_q     <= limit_d;
      iter_rem_q  <= iter_rem_d;
      error_q     <= error_d;
      err_stage_q <= err_stage_d;
      stage_en_q  <= stage_en_d;
      stage_rst_q <= stage_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef STAGE_SKIP_EN
      skip_q      <= skip_d;
`endif
    end
  end

  // Next state, bookkeeping, and output decode from the next state
  always_comb begin
    state_d     = state_q;
    cur_stage_d = cur_stage_q;
    timer_d     = timer_q;
    limit_d     = limit_q;
    iter_rem_d  = iter_rem_q;
    error_d     = error_q;
    err_stage_d = err_stage_q;
    stage_en_d  = '0;
    stage_rst_d = '1;
    busy_d      = 1'b0;
    done_d      = 1'b0;
`ifdef STAGE_SKIP_EN
    skip_d      = skip_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          limit_d     = timeout_limit;
          iter_rem_d  = (iter_count == '0) ? ITER_W'(1) : iter_count;
          error_d     = 1'b0;
          err_stage_d = '0;
`ifdef STAGE_SKIP_EN
          skip_d      = skip_mask;
`endif
          if (nxt_start[SW]) begin
            state_d     = S_RUN;
            cur_stage_d = nxt_start[SW-1:0];
            timer_d     = TIMEOUT_W'(1);
          end else begin
            // Nothing to run: complete immediately
            state_d     = S_DONE;
            cur_stage_d = '0;
            timer_d     = '0;
            iter_rem_d  = '0;
          end
        end
      end

      S_RUN: begin
        // Completion is checked first so it wins over a same-cycle timeout
        if (cur_hit) begin
          if (nxt_fwd[SW]) begin
            cur_stage_d = nxt_fwd[SW-1:0];
            timer_d     = TIMEOUT_W'(1);
          end else if (iter_rem_q > ITER_W'(1)) begin
            iter_rem_d  = iter_rem_q - ITER_W'(1);
            cur_stage_d = nxt_wrap[SW-1:0];
            timer_d     = TIMEOUT_W'(1);
          end else begin
            state_d     = S_DONE;
            cur_stage_d = '0;
            timer_d     = '0;
            iter_rem_d  = '0;
          end
        end else if (wd_fire) begin
          state_d     = S_ERR;
          error_d     = 1'b1;
          err_stage_d = cur_stage_q;
          cur_stage_d = '0;
          timer_d     = '0;
          iter_rem_d  = '0;
        end else begin
          timer_d = timer_q + TIMEOUT_W'(1);
        end
      end

      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything except the sticky error record
    if (abort) begin
      state_d     = S_IDLE;
      cur_stage_d = '0;
      timer_d     = '0;
      iter_rem_d  = '0;
      limit_d     = limit_q;
      error_d     = error_q;
      err_stage_d = err_stage_q;
`ifdef STAGE_SKIP_EN
      skip_d      = skip_q;
`endif
    end

    if (state_d == S_RUN) begin
      stage_en_d = NUM_STAGES'(1) << cur_stage_d;
      busy_d     = 1'b1;
    end
    stage_rst_d = ~stage_en_d;
    done_d      = (state_d == S_DONE);
  end

  assign stage_en       = stage_en_q;
  assign stage_rst      = stage_rst_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign err_stage      = err_stage_q;
  assign cur_stage      = cur_stage_q;
  assign iter_remaining = iter_rem_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer (NUM_STAGES=5): a table of run scenarios with
// hand-computed outcomes driven by a stage responder, plus directed sequences
// for reset, abort and sticky-error behaviour.
module tb_stage_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] iter_count = 8'd0;
  logic [15:0] timeout_limit = 16'd0;
  logic [4:0] stage_done = 5'd0;
  logic [4:0] skip_mask = 5'd0;
  logic [4:0] stage_en;
  logic [4:0] stage_rst;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] err_stage;
  logic [2:0] cur_stage;
  logic [7:0] iter_remaining;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  stage_sequencer #(.NUM_STAGES(5), .TIMEOUT_W(16), .ITER_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .iter_count(iter_count),
    .timeout_limit(timeout_limit),
    .stage_done(stage_done),
`ifdef STAGE_SKIP_EN
    .skip_mask(skip_mask),
`endif
    .stage_en(stage_en),
    .stage_rst(stage_rst),
    .busy(busy),
    .done(done),
    .error(error),
    .err_stage(err_stage),
    .cur_stage(cur_stage),
    .iter_remaining(iter_remaining)
  );

  // One scenario: inputs, responder behaviour, and expected outcome.
  // resp: enabled cycle in which the stage raises its done flag
  // hang: stage that never finishes (-1 none); spur: cycle with a stray start (0 none)
  // exp_cyc: cycle after the start edge in which busy first reads 0 (DONE or ERR)
  typedef struct {
    logic [7:0]  iter;
    logic [15:0] limit;
    int          resp;
    int          hang;
    int          spur;
    logic [4:0]  mask;
    int          exp_cyc;
    bit          exp_done;
    bit          exp_err;
    int          exp_err_stage;
    int          exp_visits;
  } vec_t;

  vec_t vecs[12];
  int   n_vec;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int onehot_idx(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Next unmasked stage after prev; wrapped is set when it comes from the top again
  function automatic int nxt_stage(input int prev, input logic [4:0] m, output bit wrapped);
    wrapped = 1'b0;
    for (int j = prev + 1; j < 5; j++) if (!m[j]) return j;
    wrapped = (prev >= 0);
    for (int j = 0; j < 5; j++) if (!m[j]) return j;
    return -1;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, " stage_en"}, stage_en, 5'b00000);
    check({tag, " stage_rst"}, stage_rst, 5'b11111);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " error"}, error, 0);
    check({tag, " err_stage"}, err_stage, 0);
    check({tag, " cur_stage"}, cur_stage, 0);
    check({tag, " iter_remaining"}, iter_remaining, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int dur, visits, order_bad, dur_bad, iter_bad, cur_bad, rst_bad;
    int exp_iter, term_cyc, prev_idx, idx, exp_idx, exp_dur;
    bit seen_done, finished, wrapped, err_at1;
    logic [4:0] prev_en;
    dur = 0; visits = 0; order_bad = 0; dur_bad = 0; iter_bad = 0; cur_bad = 0; rst_bad = 0;
    term_cyc = -1; prev_idx = -1; seen_done = 1'b0; finished = 1'b0; err_at1 = 1'b1;
    prev_en = '0;
    exp_iter = (v.iter == 8'd0) ? 1 : int'(v.iter);
    iter_count = v.iter;
    timeout_limit = v.limit;
    skip_mask = v.mask;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
      @(negedge clk);
      start = (cyc == v.spur);
      stage_done = '0;
      if (cyc == 1) err_at1 = error;
      if (done) seen_done = 1'b1;
      if (stage_en != prev_en) begin
        if (prev_en != '0) begin
          exp_dur = (v.exp_err && prev_idx == v.exp_err_stage) ? int'(v.limit) : v.resp;
          if (dur != exp_dur) dur_bad++;
        end
        if (stage_en != '0) begin
          if (!$onehot(stage_en)) order_bad++;
          idx = onehot_idx(stage_en);
          exp_idx = nxt_stage(prev_idx, v.mask, wrapped);
          if (wrapped) exp_iter--;
          if (idx != exp_idx) order_bad++;
          if (int'(iter_remaining) != exp_iter) iter_bad++;
          visits++;
          prev_idx = idx;
        end
        dur = 0;
      end
      if (stage_en != '0) begin
        dur++;
        if (int'(cur_stage) != prev_idx || !busy) cur_bad++;
        if (stage_rst != ~stage_en) rst_bad++;
        if (dur == v.resp && prev_idx != v.hang) stage_done = stage_en;
      end
      prev_en = stage_en;
      if (!busy) begin
        finished = 1'b1;
        term_cyc = cyc;
      end
    end
    start = 1'b0;
    stage_done = '0;
    check({tag, " end_cycle"}, term_cyc, v.exp_cyc);
    check({tag, " done_pulse"}, seen_done, v.exp_done);
    check({tag, " error"}, error, v.exp_err);
    if (v.exp_err) check({tag, " err_stage"}, err_stage, v.exp_err_stage);
    check({tag, " error_cleared_at_start"}, err_at1, 0);
    check({tag, " stage_visits"}, visits, v.exp_visits);
    check({tag, " order_errors"}, order_bad, 0);
    check({tag, " duration_errors"}, dur_bad, 0);
    check({tag, " iter_remaining_errors"}, iter_bad, 0);
    check({tag, " cur_stage_errors"}, cur_bad, 0);
    check({tag, " stage_rst_errors"}, rst_bad, 0);
    check({tag, " end_stage_en"}, stage_en, 5'b00000);
    check({tag, " end_stage_rst"}, stage_rst, 5'b11111);
  endtask

  initial begin
    int bad;
    // Fields: iter, limit, resp, hang, spur, mask, exp_cyc, exp_done, exp_err, exp_err_stage, exp_visits
    vecs[0] = '{8'd1, 16'd0,  3, -1,  5, 5'b00000, 16, 1'b1, 1'b0, 0, 5};
    vecs[1] = '{8'd3, 16'd0,  3, -1,  0, 5'b00000, 46, 1'b1, 1'b0, 0, 15};
    vecs[2] = '{8'd0, 16'd0,  3, -1,  0, 5'b00000, 16, 1'b1, 1'b0, 0, 5};
    vecs[3] = '{8'd1, 16'd10, 3,  2,  0, 5'b00000, 17, 1'b0, 1'b1, 2, 3};
    vecs[4] = '{8'd1, 16'd4,  4, -1,  0, 5'b00000, 21, 1'b1, 1'b0, 0, 5};
    vecs[5] = '{8'd2, 16'd0,  2, -1, 12, 5'b00000, 21, 1'b1, 1'b0, 0, 10};
    vecs[6] = '{8'd5, 16'd3,  4, -1,  0, 5'b00000,  4, 1'b0, 1'b1, 0, 1};
    vecs[7] = '{8'd1, 16'd1,  1, -1,  0, 5'b00000,  6, 1'b1, 1'b0, 0, 5};
    n_vec = 8;
`ifdef STAGE_SKIP_EN
    vecs[8]  = '{8'd1, 16'd0, 3, -1, 0, 5'b01010, 10, 1'b1, 1'b0, 0, 3};
    vecs[9]  = '{8'd2, 16'd0, 3, -1, 0, 5'b01010, 19, 1'b1, 1'b0, 0, 6};
    vecs[10] = '{8'd1, 16'd0, 3, -1, 0, 5'b11111,  1, 1'b1, 1'b0, 0, 0};
    vecs[11] = '{8'd1, 16'd0, 2, -1, 0, 5'b10001,  7, 1'b1, 1'b0, 0, 3};
    n_vec = 12;
`endif

    // Reset held low for three edges, with start asserted to show reset wins
    reset = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < n_vec; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Leave a sticky error behind, then abort alone and abort+start in IDLE
    run_vec(vecs[3], "timeout_again");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle error_kept", error, 1);
    check("abort_idle err_stage_kept", err_stage, 2);
    check("abort_idle busy", busy, 0);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_start busy", busy, 0);
    check("abort_start stage_en", stage_en, 5'b00000);
    check("abort_start error_kept", error, 1);
    @(negedge clk);
    check("abort_start still_idle", busy, 0);

    // Abort in the first cycle of stage 3
    iter_count = 8'd1;
    timeout_limit = 16'd0;
    skip_mask = 5'b00000;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      stage_done = (c % 3 == 0) ? stage_en : 5'b00000;
    end
    check("abort_run stage3_en", stage_en, 5'b01000);
    check("abort_run stage3_cur", cur_stage, 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_run busy", busy, 0);
    check("abort_run stage_en", stage_en, 5'b00000);
    check("abort_run stage_rst", stage_rst, 5'b11111);
    check("abort_run cur_stage", cur_stage, 0);
    check("abort_run done", done, 0);
    check("abort_run error", error, 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    check("abort_run quiet_after", bad, 0);

    // Reset in the middle of stage 1
    iter_count = 8'd3;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      stage_done = (c == 3) ? stage_en : 5'b00000;
    end
    check("midreset pre_cur", cur_stage, 1);
    check("midreset pre_iter", iter_remaining, 3);
    reset = 1'b0;
    @(negedge clk);
    stage_done = 5'b00000;
    check_reset_vals("midreset");
    reset = 1'b1;
    @(negedge clk);
    check("midreset stays_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
